// File: rtl/hack_fetch_unit.sv
// rtl/hack_fetch_unit.sv - Hack CPU instruction-fetch stage: PC, ROM address, stall hold, retire count, halt detect
// Optional branch-trace buffer enabled by defining HACK_BRANCH_TRACE_EN.
module hack_fetch_unit #(
   parameter logic [14:0] RESET_PC    = 15'h0000,
   parameter int          RETIRE_W    = 16,
   parameter int          TRACE_DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [15:0]            rom_data,
   input  logic                   loadPC,
   input  logic [14:0]            addressI,
   input  logic                   stall,
`ifdef HACK_BRANCH_TRACE_EN
   input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
   output logic [14:0]                    trace_src,
   output logic [14:0]                    trace_dst,
   output logic [$clog2(TRACE_DEPTH):0]   trace_cnt,
`endif
   output logic [14:0]            rom_addr,
   output logic [15:0]            instruction,
   output logic [14:0]            pc,
   output logic [RETIRE_W-1:0]    retired,
   output logic                   halted
);

   typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [14:0]         pc_q, pc_d;
   logic [RETIRE_W-1:0] retired_q, retired_d;
   logic                halted_q, halted_d;
   logic                complete;
   logic                take_jump;

   if (TRACE_DEPTH < 2 || (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("TRACE_DEPTH must be a power of 2 and at least 2");
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= RUN;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (stall) state_d = HOLD;
         HOLD:    state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // The jump decision is only final on the completing cycle, so loadPC is ignored on the first half of a stall.
   always_comb begin
      complete  = (state_q == HOLD) || !stall;
      take_jump = complete && loadPC;
   end

   always_comb begin
      pc_d      = pc_q;
      retired_d = retired_q;
      halted_d  = halted_q;
      if (complete) begin
         pc_d = take_jump ? addressI : pc_q + 15'd1;
         if (retired_q != '1) retired_d = retired_q + 1'b1;
         if (take_jump && addressI == pc_q - 15'd1) halted_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q      <= RESET_PC;
         retired_q <= '0;
         halted_q  <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         retired_q <= retired_d;
         halted_q  <= halted_d;
      end
   end

   assign pc          = pc_q;
   assign rom_addr    = pc_q;
   assign instruction = reset ? rom_data : 16'h0000;
   assign retired     = retired_q;
   assign halted      = halted_q;

`ifdef HACK_BRANCH_TRACE_EN
   localparam int IW = $clog2(TRACE_DEPTH);

   logic [IW-1:0] wr_ptr_q, wr_ptr_d;
   logic [IW:0]   cnt_q, cnt_d;
   logic [14:0]   src_q [TRACE_DEPTH];
   logic [14:0]   src_d [TRACE_DEPTH];
   logic [14:0]   dst_q [TRACE_DEPTH];
   logic [14:0]   dst_d [TRACE_DEPTH];
   logic [IW-1:0] rd_ptr;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      src_d    = src_q;
      dst_d    = dst_q;
      if (take_jump) begin
         src_d[wr_ptr_q] = pc_q;
         dst_d[wr_ptr_q] = addressI;
         wr_ptr_d        = wr_ptr_q + 1'b1;
         if (cnt_q != TRACE_DEPTH[IW:0]) cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < TRACE_DEPTH; i++) begin
            src_q[i] <= '0;
            dst_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
      end
   end

   // Index 0 is the newest entry, i.e. the slot just behind the write pointer.
   always_comb begin
      rd_ptr    = wr_ptr_q - 1'b1 - trace_idx;
      trace_cnt = cnt_q;
      trace_src = '0;
      trace_dst = '0;
      if ({1'b0, trace_idx} < cnt_q) begin
         trace_src = src_q[rd_ptr];
         trace_dst = dst_q[rd_ptr];
      end
   end
`endif

endmodule
